// File: rtl/feature_ram_pkg.sv
// Shared types and defaults for the feature-vector store: clear FSM states,
// default geometry, and the feature bit-offset helper.
package feature_ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_LENGTH     = 16;
  localparam int DEF_LEN_BITS   = 4;
  localparam int DEF_FEAT_W     = 8;

  // Feature 0 sits in the row LSBs.
  function automatic int feat_offset(input int sel, input int feat_w);
    return sel * feat_w;
  endfunction

endpackage

// File: rtl/feature_ram_clr_seq.sv
// Clear sequencer: walks every row once after reset or on a clear request,
// holding busy high while the top-level write port is borrowed.
module feature_ram_clr_seq
  import feature_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    busy_o   = 1'b0;
    clr_we_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        busy_o   = 1'b1;
        clr_we_o = 1'b1;
        // The last row is still zeroed on the exit cycle.
        if (ptr_q == LAST_ROW) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
    endcase
  end

  assign clr_addr_o = ptr_q;

endmodule

// File: rtl/feature_ram.sv
// Feature-vector store: one write port (row or single feature), one read port
// returning the row plus a selected feature, with a hardware clear sequencer.
module feature_ram
  import feature_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LENGTH     = DEF_LENGTH,
  parameter int LEN_BITS   = DEF_LEN_BITS,
  parameter int FEAT_W     = DEF_FEAT_W
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic                         wr_feat_mode,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [LEN_BITS-1:0]          wr_feat_sel,
  input  logic [LENGTH*FEAT_W-1:0]     wr_data,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [LEN_BITS-1:0]          rd_feat_sel,
  output logic [LENGTH*FEAT_W-1:0]     rd_row,
  output logic [FEAT_W-1:0]            rd_feat,
  output logic                         rd_valid,
  output logic                         busy,
  output logic                         addr_err
);

  localparam int DATA_WIDTH = LENGTH * FEAT_W;
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [LEN_BITS:0]   LENGTH_W = (LEN_BITS + 1)'(LENGTH);

  logic [DATA_WIDTH-1:0] mem_q [2**IDX_W];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  feature_ram_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clr_seq (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (clr),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  logic                  accept, wr_row_ok, wr_feat_ok, wr_go, wr_bad;
  logic                  rd_row_ok, rd_feat_ok, rd_go, rd_bad;
  int                    wr_off, rd_off;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0] wr_row_new, rd_src;
  logic [DATA_WIDTH-1:0] rd_row_d, rd_row_q;
  logic [FEAT_W-1:0]     rd_feat_d, rd_feat_q;
  logic                  rd_valid_q, addr_err_q;

  // A clear request wins over any same-cycle user access.
  always_comb begin
    accept     = !RST && !busy && !clr;
    wr_row_ok  = {1'b0, wr_addr} < DEPTH_W;
    wr_feat_ok = !wr_feat_mode || ({1'b0, wr_feat_sel} < LENGTH_W);
    rd_row_ok  = {1'b0, rd_addr} < DEPTH_W;
    rd_feat_ok = {1'b0, rd_feat_sel} < LENGTH_W;
    wr_go      = accept && wr_en && wr_row_ok && wr_feat_ok;
    wr_bad     = accept && wr_en && !(wr_row_ok && wr_feat_ok);
    rd_go      = accept && rd_en;
    rd_bad     = rd_go && !(rd_row_ok && rd_feat_ok);
    wr_idx     = wr_row_ok ? wr_addr[IDX_W-1:0] : '0;
    rd_idx     = rd_row_ok ? rd_addr[IDX_W-1:0] : '0;
    wr_off     = wr_feat_ok ? feat_offset(int'(wr_feat_sel), FEAT_W) : 0;
    rd_off     = rd_feat_ok ? feat_offset(int'(rd_feat_sel), FEAT_W) : 0;

    wr_row_new = wr_data;
    if (wr_feat_mode) begin
      wr_row_new = mem_q[wr_idx];
      wr_row_new[wr_off +: FEAT_W] = wr_data[FEAT_W-1:0];
    end

    // Write-first forwarding when both ports hit the same row.
    rd_src = (wr_go && (wr_addr == rd_addr)) ? wr_row_new : mem_q[rd_idx];
    rd_row_d  = rd_row_ok ? rd_src : '0;
    rd_feat_d = (rd_row_ok && rd_feat_ok) ? rd_src[rd_off +: FEAT_W] : '0;
  end

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem_q[clr_addr[IDX_W-1:0]] <= '0;
    end else if (wr_go) begin
      mem_q[wr_idx] <= wr_row_new;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_row_q   <= '0;
      rd_feat_q  <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_go;
      addr_err_q <= wr_bad || rd_bad;
      if (rd_go) begin
        rd_row_q  <= rd_row_d;
        rd_feat_q <= rd_feat_d;
      end
    end
  end

  assign rd_row   = rd_row_q;
  assign rd_feat  = rd_feat_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_feature_ram.sv
// Directed bench for feature_ram with a behavioural row model and a read
// scoreboard; every cycle checks busy, rd_valid, addr_err and read data.
module tb_feature_ram;

  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 4;
  localparam int LENGTH     = 16;
  localparam int LEN_BITS   = 4;
  localparam int FEAT_W     = 8;
  localparam int DATA_WIDTH = LENGTH * FEAT_W;

  logic                  CLK = 1'b0;
  logic                  RST, clr, wr_en, wr_feat_mode, rd_en;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic [LEN_BITS-1:0]   wr_feat_sel, rd_feat_sel;
  logic [DATA_WIDTH-1:0] wr_data, rd_row;
  logic [FEAT_W-1:0]     rd_feat;
  logic                  rd_valid, busy, addr_err;

  feature_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .LENGTH     (LENGTH),
    .LEN_BITS   (LEN_BITS),
    .FEAT_W     (FEAT_W)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .clr          (clr),
    .wr_en        (wr_en),
    .wr_feat_mode (wr_feat_mode),
    .wr_addr      (wr_addr),
    .wr_feat_sel  (wr_feat_sel),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_feat_sel  (rd_feat_sel),
    .rd_row       (rd_row),
    .rd_feat      (rd_feat),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .addr_err     (addr_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DATA_WIDTH-1:0] row;
    logic [FEAT_W-1:0]     feat;
  } rd_exp_t;

  rd_exp_t               sbq[$];
  logic [DATA_WIDTH-1:0] m_mem [8];
  logic                  m_busy = 1'b1;
  int                    m_ptr = 0;
  logic [DATA_WIDTH-1:0] last_row = '0;
  logic [FEAT_W-1:0]     last_feat = '0;
  int                    n_cmp = 0;
  int                    n_bad = 0;

  task automatic chk(input string tag, input logic [DATA_WIDTH-1:0] obs,
                     input logic [DATA_WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict from current inputs, advance the model, check outputs.
  task automatic tick();
    logic          exp_valid, exp_err;
    rd_exp_t       e;
    logic [DATA_WIDTH-1:0] row;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (!RST && !m_busy && !clr) begin
      if (wr_en) begin
        if (wr_addr >= DEPTH || (wr_feat_mode && wr_feat_sel >= LENGTH)) exp_err = 1'b1;
        else if (wr_feat_mode) m_mem[wr_addr][wr_feat_sel*FEAT_W +: FEAT_W] = wr_data[FEAT_W-1:0];
        else m_mem[wr_addr] = wr_data;
      end
      if (rd_en) begin
        exp_valid = 1'b1;
        row = (rd_addr < DEPTH) ? m_mem[rd_addr] : '0;
        if (rd_addr >= DEPTH || rd_feat_sel >= LENGTH) exp_err = 1'b1;
        e.row  = row;
        e.feat = (rd_addr < DEPTH && rd_feat_sel < LENGTH) ? row[rd_feat_sel*FEAT_W +: FEAT_W] : '0;
        sbq.push_back(e);
      end
    end
    if (RST) begin
      m_busy = 1'b1;
      m_ptr  = 0;
    end else if (m_busy) begin
      m_mem[m_ptr] = '0;
      if (m_ptr == DEPTH - 1) m_busy = 1'b0;
      else m_ptr++;
    end else if (clr) begin
      m_busy = 1'b1;
      m_ptr  = 0;
    end
    @(posedge CLK);
    #1;
    chk("busy", busy, m_busy);
    chk("rd_valid", rd_valid, exp_valid);
    chk("addr_err", addr_err, exp_err);
    if (RST) begin
      last_row  = '0;
      last_feat = '0;
    end
    if (exp_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rd_row", rd_row, e.row);
      chk("rd_feat", rd_feat, e.feat);
      last_row  = e.row;
      last_feat = e.feat;
    end else begin
      chk("rd_row_hold", rd_row, last_row);
      chk("rd_feat_hold", rd_feat, last_feat);
    end
  endtask

  task automatic idle_inputs();
    clr = 0; wr_en = 0; wr_feat_mode = 0; rd_en = 0;
    wr_addr = '0; rd_addr = '0; wr_feat_sel = '0; rd_feat_sel = '0; wr_data = '0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    idle_inputs();
    RST = 1;
    repeat (3) tick();
    RST = 0;
    repeat (4) tick();

    // Preload 0xFF everywhere, then reset and confirm every row is zeroed.
    for (int r = 0; r < DEPTH; r++) begin
      wr_en = 1; wr_addr = ADDR_WIDTH'(r); wr_data = '1;
      tick();
    end
    idle_inputs();
    RST = 1;
    repeat (3) tick();
    RST = 0;
    repeat (4) tick();
    for (int r = 0; r < DEPTH; r++) begin
      rd_en = 1; rd_addr = ADDR_WIDTH'(r); rd_feat_sel = 4'(r);
      tick();
      chk("cleared_row", rd_row, '0);
    end
    idle_inputs();
    tick();

    // Full-row write then read with feature select 2.
    wr_en = 1; wr_addr = 3'd1; wr_data = 128'h0F0E0D0C0B0A09080706050403020100;
    tick();
    idle_inputs();
    rd_en = 1; rd_addr = 3'd1; rd_feat_sel = 4'd2;
    tick();
    chk("row1_feat2", rd_feat, 8'h02);

    // Feature write with same-row read: write-first.
    idle_inputs();
    wr_en = 1; wr_feat_mode = 1; wr_addr = 3'd1; wr_feat_sel = 4'd5; wr_data = 128'hAA;
    rd_en = 1; rd_addr = 3'd1; rd_feat_sel = 4'd5;
    tick();
    chk("wf_feat5", rd_row[47:40], 8'hAA);
    chk("wf_feat4", rd_row[39:32], 8'h04);

    // Out-of-range write and read.
    idle_inputs();
    wr_en = 1; wr_addr = 3'd5; wr_data = '1;
    rd_en = 1; rd_addr = 3'd6; rd_feat_sel = 4'd3;
    tick();
    chk("bad_err", addr_err, 1'b1);
    idle_inputs();
    tick();
    for (int r = 0; r < DEPTH; r++) begin
      rd_en = 1; rd_addr = ADDR_WIDTH'(r);
      tick();
    end
    idle_inputs();

    // Independent write/read on different rows, then randomised traffic.
    wr_en = 1; wr_addr = 3'd2; wr_data = 128'h1234;
    rd_en = 1; rd_addr = 3'd1; rd_feat_sel = 4'd0;
    tick();
    for (int i = 0; i < 24; i++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_feat_mode = 1'($urandom_range(0, 1));
      wr_addr = 3'($urandom_range(0, 4)); wr_feat_sel = 4'($urandom_range(0, 15));
      wr_data = {$urandom, $urandom, $urandom, $urandom};
      rd_en = 1'($urandom_range(0, 1)); rd_addr = 3'($urandom_range(0, 4));
      rd_feat_sel = 4'($urandom_range(0, 15));
      tick();
    end
    idle_inputs();
    for (int r = 0; r < DEPTH; r++) begin
      wr_en = 1; wr_addr = ADDR_WIDTH'(r); wr_data = {4{32'h5A5A0000 + 32'(r)}};
      tick();
    end
    idle_inputs();
    rd_en = 1; rd_addr = 3'd3; rd_feat_sel = 4'd1;
    tick();

    // Clear request with a same-cycle write, reads ignored while busy, RST mid-clear.
    idle_inputs();
    clr = 1; wr_en = 1; wr_addr = 3'd2; wr_data = '1;
    tick();
    idle_inputs();
    rd_en = 1; rd_addr = 3'd0;
    repeat (2) tick();
    chk("busy_rd_hold", rd_valid, 1'b0);
    RST = 1;
    tick();
    RST = 0;
    repeat (4) tick();
    idle_inputs();
    for (int r = 0; r < DEPTH; r++) begin
      rd_en = 1; rd_addr = ADDR_WIDTH'(r); rd_feat_sel = 4'd7;
      tick();
      chk("clr_row_zero", rd_row, '0);
    end
    idle_inputs();
    tick();
    chk("sb_drained", 128'(sbq.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/feature_ram.md
Name: feature_ram

Overview:
Parametrised, fully synchronous feature-vector store for the classifier datapath. Each row holds LENGTH features of FEAT_W bits for one data point.
- One write port and one read port, usable in the same cycle.
- Writes are either a full row or a single feature; reads return the full row plus one selected feature.
- A hardware clear sequencer zeroes every row after reset or on request.
- Sits between the training-data loader and the distance/compare engine.

Parameters:
ADDR_WIDTH, 3, row address bits
DEPTH, 4, number of rows (data points); DEPTH <= 2**ADDR_WIDTH
LENGTH, 16, features per row
LEN_BITS, 4, feature-select bits; LENGTH <= 2**LEN_BITS
FEAT_W, 8, bits per feature
DATA_WIDTH (localparam), LENGTH*FEAT_W = 128, row width

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
clr  in  1  request a full clear (sampled in IDLE only)
wr_en  in  1  write request
wr_feat_mode  in  1  0 = full-row write, 1 = single-feature write
wr_addr  in  ADDR_WIDTH  write row
wr_feat_sel  in  LEN_BITS  feature index for a feature write
wr_data  in  DATA_WIDTH  row data; feature write uses bits [FEAT_W-1:0]
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read row
rd_feat_sel  in  LEN_BITS  feature index for rd_feat
rd_row  out  DATA_WIDTH  registered row data
rd_feat  out  FEAT_W  registered selected feature
rd_valid  out  1  one-cycle pulse, read data valid
busy  out  1  high while clearing; requests are dropped
addr_err  out  1  one-cycle pulse on any out-of-range address or feature index

Behaviour:
- Feature f occupies row bits [f*FEAT_W +: FEAT_W]; feature 0 is at the LSBs.
- Reset: while RST=1 the state is CLEAR, clr_ptr=0, busy=1, and rd_row, rd_feat, rd_valid, addr_err are all 0. RST asserted mid-clear restarts from clr_ptr=0.
- FSM states are IDLE and CLEAR.
  - CLEAR: each cycle mem[clr_ptr] <= 0 and clr_ptr++.
  - When clr_ptr == DEPTH-1 that row is cleared and the next state is IDLE.
  - Every row 0..DEPTH-1 is zeroed, including the last one.
  - Clear takes exactly DEPTH cycles after RST falls; busy is 1 throughout CLEAR.
- IDLE with clr=1: next state is CLEAR with clr_ptr=0. Any wr_en or rd_en in that cycle is dropped (clr has priority).
- In CLEAR, wr_en and rd_en are ignored: no write, no rd_valid, no addr_err.
- Write (IDLE, wr_en=1): takes effect at the clock edge.
  - Full-row write replaces the row.
  - Feature write updates only feature wr_feat_sel; other features are unchanged.
- Read (IDLE, rd_en=1 at edge n):
  - rd_row, rd_feat and rd_valid=1 appear after edge n+1 (latency 1).
  - Outputs hold their last value while rd_valid=0.
- Same row read and written in the same cycle: write-first. Read data reflects the merged new row.
- Out of range (wr_addr >= DEPTH, rd_addr >= DEPTH, or a feature index >= LENGTH):
  - Writes: the write is suppressed.
  - Reads: rd_valid=1 with rd_row=0 and rd_feat=0 for a bad row; rd_feat=0 only for a bad feature index.
  - addr_err pulses one cycle, aligned with the would-be write edge or with rd_valid. Read and write errors in the same cycle give a single pulse.
- Simultaneous wr_en and rd_en at different rows are fully independent.

Decomposition:
- Package feature_ram_pkg holds the state enum {IDLE, CLEAR}, default parameter constants, and a function computing a feature's bit offset.
- One sub-module, feature_ram_clr_seq, holds the FSM, clr_ptr, busy, and the clear write-enable/address. The top level muxes the clear write against the user write port.

Test Plan:
- RST high 3 cycles, then low -> busy=1 for exactly 4 cycles; reading rows 0..3 then returns 0. Preload rows with 0xFF first to prove row 3 is cleared.
- Full write row 1 = 128'h0F0E...0100, then read row 1 with feat_sel=2 -> next cycle rd_valid=1, rd_row equals the written value, rd_feat=8'h02.
- Feature write row 1, feat 5, value 8'hAA, with a same-cycle read of row 1 -> rd_row has 8'hAA at bits [47:40], all other features unchanged (write-first).
- Write at addr 5 and read at addr 6 with DEPTH=4 -> no memory change; rd_valid=1, rd_row=0, addr_err pulses once.
- clr=1 together with wr_en in IDLE -> write dropped; busy=1 for 4 cycles and all rows read 0. RST pulsed at clear cycle 2 -> clear restarts and busy lasts 4 cycles from RST falling.
- rd_en during busy -> no rd_valid; rd_row keeps its prior value.
